// File: rtl/ls_queue.sv
// In-order load/store issue queue with CDB operand snooping; issue is registered one cycle after head-ready && lsReadEn.
// Backpressure: the dispatcher watches bufFree/full (alloc while full is dropped); the LS unit throttles issue with lsReadEn.
module ls_queue #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter int NAME_W  = 5,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CDB-1:0]          cdbEn,
  input  logic [NUM_CDB*TAG_W-1:0]    cdbTag,
  input  logic [NUM_CDB*DATA_W-1:0]   cdbData,
  input  logic                        allocEn,
  input  logic [DATA_W-1:0]           allocOperandO,
  input  logic [DATA_W-1:0]           allocOperandT,
  input  logic [TAG_W-1:0]            allocTagO,
  input  logic [TAG_W-1:0]            allocTagT,
  input  logic [TAG_W-1:0]            allocTagW,
  input  logic [NAME_W-1:0]           allocNameW,
  input  logic [OP_W-1:0]             allocOp,
  input  logic [DATA_W-1:0]           allocImm,
  input  logic                        flush,
  input  logic                        lsReadEn,
  output logic                        issueEn,
  output logic [DATA_W-1:0]           issueOperandO,
  output logic [DATA_W-1:0]           issueOperandT,
  output logic [DATA_W-1:0]           issueImm,
  output logic [TAG_W-1:0]            issueTagW,
  output logic [NAME_W-1:0]           issueNameW,
  output logic [OP_W-1:0]             issueOp,
  output logic [PTR_W:0]              count,
  output logic                        full,
  output logic                        empty,
  output logic                        bufFree
);

  localparam logic [TAG_W-1:0] TAG_FREE = '1;
  localparam logic [OP_W-1:0]  NOP_OP   = '0;
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } snoop_t;

  logic              vld    [DEPTH];
  logic [DATA_W-1:0] opnd_o [DEPTH];
  logic [DATA_W-1:0] opnd_t [DEPTH];
  logic [TAG_W-1:0]  tag_o  [DEPTH];
  logic [TAG_W-1:0]  tag_t  [DEPTH];
  logic [TAG_W-1:0]  tag_w  [DEPTH];
  logic [NAME_W-1:0] name_w [DEPTH];
  logic [OP_W-1:0]   op     [DEPTH];
  logic [DATA_W-1:0] imm    [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;

  snoop_t            snp_o [DEPTH];
  snoop_t            snp_t [DEPTH];
  snoop_t            alloc_snp_o;
  snoop_t            alloc_snp_t;
  logic              head_rdy;
  logic              do_issue;
  logic              do_alloc;

  // Descending scan so the lowest-index matching channel is the one that sticks.
  function automatic snoop_t snoop(input logic [TAG_W-1:0] tag);
    snoop_t s;
    s.hit  = 1'b0;
    s.data = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdbEn[k] && (tag != TAG_FREE) && (cdbTag[k*TAG_W +: TAG_W] == tag)) begin
        s.hit  = 1'b1;
        s.data = cdbData[k*DATA_W +: DATA_W];
      end
    end
    return s;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      snp_o[i] = snoop(tag_o[i]);
      snp_t[i] = snoop(tag_t[i]);
    end
    alloc_snp_o = snoop(allocTagO);
    alloc_snp_t = snoop(allocTagT);
  end

  // Readiness looks only at registered tags; a same-cycle broadcast helps next cycle.
  assign head_rdy = vld[head] && (tag_o[head] == TAG_FREE) && (tag_t[head] == TAG_FREE);
  assign do_issue = lsReadEn && head_rdy && !flush;
  assign do_alloc = allocEn && !full && !flush;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign bufFree = (count + (PTR_W + 1)'(allocEn)) < DEPTH_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      issueEn       <= 1'b0;
      issueOp       <= NOP_OP;
      issueTagW     <= TAG_FREE;
      issueNameW    <= '0;
      issueOperandO <= '0;
      issueOperandT <= '0;
      issueImm      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        vld[i]    <= 1'b0;
        opnd_o[i] <= '0;
        opnd_t[i] <= '0;
        tag_o[i]  <= TAG_FREE;
        tag_t[i]  <= TAG_FREE;
        tag_w[i]  <= TAG_FREE;
        name_w[i] <= '0;
        op[i]     <= NOP_OP;
        imm[i]    <= '0;
      end
    end else begin
      issueEn       <= 1'b0;
      issueOp       <= NOP_OP;
      issueTagW     <= TAG_FREE;
      issueNameW    <= '0;
      issueOperandO <= '0;
      issueOperandT <= '0;
      issueImm      <= '0;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) vld[i] <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld[i] && snp_o[i].hit) begin
            opnd_o[i] <= snp_o[i].data;
            tag_o[i]  <= TAG_FREE;
          end
          if (vld[i] && snp_t[i].hit) begin
            opnd_t[i] <= snp_t[i].data;
            tag_t[i]  <= TAG_FREE;
          end
        end
        if (do_issue) begin
          issueEn       <= 1'b1;
          issueOp       <= op[head];
          issueTagW     <= tag_w[head];
          issueNameW    <= name_w[head];
          issueOperandO <= opnd_o[head];
          issueOperandT <= opnd_t[head];
          issueImm      <= imm[head];
          vld[head]     <= 1'b0;
          head          <= ptr_inc(head);
        end
        if (do_alloc) begin
          vld[tail]    <= 1'b1;
          opnd_o[tail] <= alloc_snp_o.hit ? alloc_snp_o.data : allocOperandO;
          tag_o[tail]  <= alloc_snp_o.hit ? TAG_FREE : allocTagO;
          opnd_t[tail] <= alloc_snp_t.hit ? alloc_snp_t.data : allocOperandT;
          tag_t[tail]  <= alloc_snp_t.hit ? TAG_FREE : allocTagT;
          tag_w[tail]  <= allocTagW;
          name_w[tail] <= allocNameW;
          op[tail]     <= allocOp;
          imm[tail]    <= allocImm;
          tail         <= ptr_inc(tail);
        end
        if (do_alloc && !do_issue) begin
          count <= count + 1'b1;
        end else if (!do_alloc && do_issue) begin
          count <= count - 1'b1;
        end
      end
    end
  end

endmodule
